// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU.
// Opcodes, one-hot T-states and control-word bit indices.
package cpu_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam int CW_W       = 12;
    localparam int CW_PC_INC  = 11;
    localparam int CW_PC_OUT  = 10;
    localparam int CW_MAR_IN  = 9;
    localparam int CW_RAM_OUT = 8;
    localparam int CW_IR_IN   = 7;
    localparam int CW_IR_OUT  = 6;
    localparam int CW_A_IN    = 5;
    localparam int CW_A_OUT   = 4;
    localparam int CW_B_IN    = 3;
    localparam int CW_ALU_SUB = 2;
    localparam int CW_ALU_OUT = 1;
    localparam int CW_OUT_IN  = 0;

    typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// ir_opcode in; all load/drive strobes, t_state, halted out.
// CTRL_SEQ_STEP_EN adds step_mode/step single-step inputs.
interface ctrl_seq_if;

    logic [3:0] ir_opcode;
    logic       pc_inc;
    logic       pc_out;
    logic       mar_in;
    logic       ram_out;
    logic       ir_in;
    logic       ir_out;
    logic       a_in;
    logic       a_out;
    logic       b_in;
    logic       alu_sub;
    logic       alu_out;
    logic       out_in;
    logic [5:0] t_state;
    logic       halted;
`ifdef CTRL_SEQ_STEP_EN
    logic       step_mode;
    logic       step;

    modport master (
        input  ir_opcode, step_mode, step,
        output pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
        output a_in, a_out, b_in, alu_sub, alu_out, out_in,
        output t_state, halted
    );

    modport slave (
        output ir_opcode, step_mode, step,
        input  pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
        input  a_in, a_out, b_in, alu_sub, alu_out, out_in,
        input  t_state, halted
    );
`else
    modport master (
        input  ir_opcode,
        output pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
        output a_in, a_out, b_in, alu_sub, alu_out, out_in,
        output t_state, halted
    );

    modport slave (
        output ir_opcode,
        input  pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
        input  a_in, a_out, b_in, alu_sub, alu_out, out_in,
        input  t_state, halted
    );
`endif

endinterface

// File: rtl/tstate_ring.sv
// Six-state one-hot T-state ring, bit0 = T1.
// Ports: clk, rst (sync, active-high), advance, hold, t_state.
module tstate_ring
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       hold,
    output logic [5:0] t_state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state <= T1;
        end else if (advance && !hold) begin
            t_state <= {t_state[4:0], t_state[5]};
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: T-state ring plus opcode decode into strobes.
// Ports: clk, rst (sync, active-high), bus (ctrl_seq_if.master).
// Optional macro CTRL_SEQ_STEP_EN enables single-step via bus.step.
module ctrl_seq
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ctrl_seq_if.master bus
);

    logic       go;
    logic       halted_q;
    logic [5:0] t_state;
    cw_t        cw;
    cw_t        cw_q;

`ifdef CTRL_SEQ_STEP_EN
    assign go = !bus.step_mode || bus.step;
`else
    assign go = 1'b1;
`endif

    tstate_ring u_ring (
        .clk     (clk),
        .rst     (rst),
        .advance (go),
        .hold    (halted_q),
        .t_state (t_state)
    );

    // Ring moves T4->T5 on the same edge; hold then parks it at T5.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (go && t_state == T4 &&
                     bus.ir_opcode == OP_HLT) begin
            halted_q <= 1'b1;
        end
    end

    always_comb begin
        cw = '0;
        unique case (t_state)
            T1: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_IN] = 1'b1;
            end
            T2: cw[CW_PC_INC] = 1'b1;
            T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_IN]   = 1'b1;
            end
            T4: begin
                unique case (bus.ir_opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                unique case (bus.ir_opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_IN]    = 1'b1;
                        cw[CW_ALU_SUB] = (bus.ir_opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            T6: begin
                unique case (bus.ir_opcode)
                    OP_ADD, OP_SUB: begin
                        cw[CW_ALU_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                        cw[CW_ALU_SUB] = (bus.ir_opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Gating by go keeps a held state from repeating its strobes.
    assign cw_q = (rst || halted_q || !go) ? '0 : cw;

    assign bus.pc_inc  = cw_q[CW_PC_INC];
    assign bus.pc_out  = cw_q[CW_PC_OUT];
    assign bus.mar_in  = cw_q[CW_MAR_IN];
    assign bus.ram_out = cw_q[CW_RAM_OUT];
    assign bus.ir_in   = cw_q[CW_IR_IN];
    assign bus.ir_out  = cw_q[CW_IR_OUT];
    assign bus.a_in    = cw_q[CW_A_IN];
    assign bus.a_out   = cw_q[CW_A_OUT];
    assign bus.b_in    = cw_q[CW_B_IN];
    assign bus.alu_sub = cw_q[CW_ALU_SUB];
    assign bus.alu_out = cw_q[CW_ALU_OUT];
    assign bus.out_in  = cw_q[CW_OUT_IN];
    assign bus.t_state = t_state;
    assign bus.halted  = halted_q;

    a_bus_excl : assert property (@(posedge clk)
        $onehot0({cw_q[CW_PC_OUT], cw_q[CW_RAM_OUT], cw_q[CW_IR_OUT],
                  cw_q[CW_A_OUT], cw_q[CW_ALU_OUT]}));

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq.
// Expected strobe words are hand-built constants below.
module tb_ctrl_seq;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    ctrl_seq_if ifc ();

    ctrl_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: pc_inc pc_out mar_in ram_out ir_in ir_out
    //            a_in a_out b_in alu_sub alu_out out_in
    localparam logic [11:0] S_NONE  = 12'h000;
    localparam logic [11:0] S_PCINC = 12'b1000_0000_0000;
    localparam logic [11:0] S_PCOUT = 12'b0100_0000_0000;
    localparam logic [11:0] S_MARIN = 12'b0010_0000_0000;
    localparam logic [11:0] S_RAMO  = 12'b0001_0000_0000;
    localparam logic [11:0] S_IRIN  = 12'b0000_1000_0000;
    localparam logic [11:0] S_IROUT = 12'b0000_0100_0000;
    localparam logic [11:0] S_AIN   = 12'b0000_0010_0000;
    localparam logic [11:0] S_AOUT  = 12'b0000_0001_0000;
    localparam logic [11:0] S_BIN   = 12'b0000_0000_1000;
    localparam logic [11:0] S_SUB   = 12'b0000_0000_0100;
    localparam logic [11:0] S_ALUO  = 12'b0000_0000_0010;
    localparam logic [11:0] S_OUTIN = 12'b0000_0000_0001;

    function automatic logic [11:0] obs();
        return {ifc.pc_inc, ifc.pc_out, ifc.mar_in, ifc.ram_out,
                ifc.ir_in, ifc.ir_out, ifc.a_in, ifc.a_out,
                ifc.b_in, ifc.alu_sub, ifc.alu_out, ifc.out_in};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction starting in T1; ends back in T1.
    task automatic test_instr(input logic [3:0] op, input string nm,
                              input logic [11:0] e4,
                              input logic [11:0] e5,
                              input logic [11:0] e6);
        logic [11:0] exp_s [6];
        logic [5:0]  exp_t;
        exp_s[0] = S_PCOUT | S_MARIN;
        exp_s[1] = S_PCINC;
        exp_s[2] = S_RAMO | S_IRIN;
        exp_s[3] = e4;
        exp_s[4] = e5;
        exp_s[5] = e6;
        exp_t = 6'b000001;
        for (int c = 0; c < 6; c++) begin
            // opcode is garbage during fetch; valid from T4
            ifc.ir_opcode = (c < 3) ? 4'hF : op;
            #1;
            n_vec++;
            if (obs() !== exp_s[c] || ifc.t_state !== exp_t) begin
                n_bad++;
                $display("FAIL %s T%0d: got strobes=%b t=%b want %b t=%b",
                         nm, c + 1, obs(), ifc.t_state, exp_s[c], exp_t);
            end
            exp_t = {exp_t[4:0], exp_t[5]};
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.ir_opcode = 4'h0;
        tick();
        tick();
        n_vec++;
        if (obs() !== S_NONE || ifc.t_state !== 6'b000001 ||
            ifc.halted !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got strobes=%b t=%b h=%b want 0 000001 0",
                     obs(), ifc.t_state, ifc.halted);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_lda();
        test_instr(4'h0, "lda", S_IROUT | S_MARIN, S_RAMO | S_AIN, S_NONE);
        #1;
        n_vec++;
        if (ifc.t_state !== 6'b000001) begin
            n_bad++;
            $display("FAIL lda_wrap: got t=%b want 000001", ifc.t_state);
        end
    endtask

    task automatic test_add_sub();
        test_instr(4'h2, "sub", S_IROUT | S_MARIN,
                   S_RAMO | S_BIN | S_SUB, S_ALUO | S_AIN | S_SUB);
        test_instr(4'h1, "add", S_IROUT | S_MARIN,
                   S_RAMO | S_BIN, S_ALUO | S_AIN);
    endtask

    task automatic test_out_nop();
        test_instr(4'hE, "out", S_AOUT | S_OUTIN, S_NONE, S_NONE);
        test_instr(4'h7, "nop", S_NONE, S_NONE, S_NONE);
    endtask

    task automatic test_back_to_back();
        test_instr(4'h0, "b2b_lda", S_IROUT | S_MARIN,
                   S_RAMO | S_AIN, S_NONE);
        test_instr(4'h2, "b2b_sub", S_IROUT | S_MARIN,
                   S_RAMO | S_BIN | S_SUB, S_ALUO | S_AIN | S_SUB);
    endtask

    task automatic test_hlt();
        int bad;
        ifc.ir_opcode = 4'h0;
        for (int c = 0; c < 3; c++) tick();
        ifc.ir_opcode = 4'hF;
        #1;
        n_vec++;
        if (obs() !== S_NONE || ifc.t_state !== 6'b001000 ||
            ifc.halted !== 1'b0) begin
            n_bad++;
            $display("FAIL hlt_t4: got strobes=%b t=%b h=%b want 0 001000 0",
                     obs(), ifc.t_state, ifc.halted);
        end
        tick();
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            ifc.ir_opcode = 4'(c);
            #1;
            n_vec++;
            if (obs() !== S_NONE || ifc.t_state !== 6'b010000 ||
                ifc.halted !== 1'b1) begin
                n_bad++;
                if (bad < 4)
                    $display("FAIL hlt_hold[%0d]: got s=%b t=%b h=%b want 0 010000 1",
                             c, obs(), ifc.t_state, ifc.halted);
                bad++;
            end
            tick();
        end
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        ifc.ir_opcode = 4'h0;
        #1;
        n_vec++;
        if (obs() !== (S_PCOUT | S_MARIN) || ifc.t_state !== 6'b000001 ||
            ifc.halted !== 1'b0) begin
            n_bad++;
            $display("FAIL hlt_rst: got s=%b t=%b h=%b want %b 000001 0",
                     obs(), ifc.t_state, ifc.halted, S_PCOUT | S_MARIN);
        end
    endtask

    task automatic test_rst_mid();
        ifc.ir_opcode = 4'h1;
        for (int c = 0; c < 4; c++) tick();
        #1;
        n_vec++;
        if (obs() !== (S_RAMO | S_BIN) || ifc.t_state !== 6'b010000) begin
            n_bad++;
            $display("FAIL rstmid_t5: got s=%b t=%b want %b 010000",
                     obs(), ifc.t_state, S_RAMO | S_BIN);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (obs() !== S_NONE) begin
            n_bad++;
            $display("FAIL rstmid_drop: got s=%b want 0", obs());
        end
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if (obs() !== (S_PCOUT | S_MARIN) || ifc.t_state !== 6'b000001) begin
            n_bad++;
            $display("FAIL rstmid_t1: got s=%b t=%b want %b 000001",
                     obs(), ifc.t_state, S_PCOUT | S_MARIN);
        end
    endtask

`ifdef CTRL_SEQ_STEP_EN
    task automatic test_step();
        int         n_inc;
        logic [5:0] prev;
        logic       stp;
        ifc.step_mode = 1'b1;
        ifc.ir_opcode = 4'h0;
        n_inc = 0;
        for (int c = 0; c < 24; c++) begin
            stp = (c % 4 == 3);
            ifc.step = stp;
            #1;
            if (ifc.pc_inc === 1'b1) n_inc++;
            prev = ifc.t_state;
            tick();
            n_vec++;
            if ((ifc.t_state !== prev) !== stp) begin
                n_bad++;
                $display("FAIL step_adv[%0d]: got t=%b from %b step=%b",
                         c, ifc.t_state, prev, stp);
            end
        end
        n_vec++;
        if (n_inc !== 1 || ifc.t_state !== 6'b000001) begin
            n_bad++;
            $display("FAIL step_pcinc: got %0d t=%b want 1 000001",
                     n_inc, ifc.t_state);
        end
        ifc.step_mode = 1'b0;
        ifc.step = 1'b0;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        ifc.ir_opcode = 4'h0;
`ifdef CTRL_SEQ_STEP_EN
        ifc.step_mode = 1'b0;
        ifc.step = 1'b0;
`endif
        test_reset();
        test_lda();
        test_add_sub();
        test_out_nop();
        test_back_to_back();
        test_rst_mid();
        test_hlt();
`ifdef CTRL_SEQ_STEP_EN
        test_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Control sequencer for the 8-bit accumulator CPU. It runs a fixed six-state T-state ring and decodes the IR opcode into the per-cycle control word. The control word drives the program counter, MAR, RAM, IR, A/B registers, ALU and output register over the shared 8-bit bus. `ctrl_seq` is the only source of every load (`*_in`) and drive (`*_out`) strobe in the core, including `mar_in` for the MAR.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ir_opcode`  in  4  upper nibble of the instruction register
- `pc_inc`  out  1  program counter increments this edge
- `pc_out`  out  1  PC drives bus[3:0]
- `mar_in`  out  1  MAR loads bus[3:0] this edge
- `ram_out`  out  1  RAM[MAR] drives bus
- `ir_in`  out  1  IR loads bus
- `ir_out`  out  1  IR address nibble drives bus[3:0]
- `a_in`  out  1  accumulator loads bus
- `a_out`  out  1  accumulator drives bus
- `b_in`  out  1  B register loads bus
- `alu_sub`  out  1  ALU computes A−B; 0 means A+B
- `alu_out`  out  1  ALU result drives bus
- `out_in`  out  1  output register loads bus
- `t_state`  out  6  one-hot ring, bit0 = T1
- `halted`  out  1  HLT executed; sequencer frozen

## Operation
- Ring T1→T2→T3→T4→T5→T6→T1, advancing one state per cycle.
- Control outputs are a combinational decode of (`t_state`, `ir_opcode`) and are gated low while `halted`.
- Fetch, all opcodes:
  - T1: `pc_out` and `mar_in`.
  - T2: `pc_inc`.
  - T3: `ram_out` and `ir_in`.
- Execute (`ir_opcode` is valid from T4 onward):
  - LDA 4'h0:
    - T4: `ir_out`, `mar_in`.
    - T5: `ram_out`, `a_in`.
    - T6: none.
  - ADD 4'h1:
    - T4: `ir_out`, `mar_in`.
    - T5: `ram_out`, `b_in`.
    - T6: `alu_out`, `a_in`.
  - SUB 4'h2: same as ADD, with `alu_sub`=1 in T5 and T6.
  - OUT 4'hE:
    - T4: `a_out`, `out_in`.
    - T5, T6: none.
  - HLT 4'hF:
    - T4: no strobes; `halted` is set at the end of T4.
    - The ring holds at T5 forever; all strobes stay 0 until `rst`.
  - Any other opcode: NOP. T4–T6 produce no strobes.
- Bus exclusivity: at most one `*_out` is high in any cycle. Assert this in RTL.

## Timing
- While `rst`=1:
  - every control output is forced 0;
  - on the edge, `t_state` is set to 6'b000001 and `halted` to 0.
- First cycle after `rst` deasserts is T1, so `pc_out`=`mar_in`=1 in that cycle.
- Instruction latency is exactly 6 cycles for every non-HLT opcode. There is no early termination.
- Strobes act on the rising edge that ends the cycle in which they are high.
- `rst` asserted mid-instruction: the next edge returns to T1 and clears `halted`. Strobes drop in the same cycle `rst` rises.
- The `ir_opcode` value present during T3 is ignored, because IR is still loading.

## Configuration
- `CTRL_SEQ_STEP_EN` defined:
  - Adds two inputs: `step_mode` (in, 1) and `step` (in, 1).
  - When `step_mode`=1, the ring advances and control outputs are asserted only in cycles where `step`=1. Strobes are ANDed with `step`, so a held state never repeats `pc_inc`.
  - When `step_mode`=0, behaviour is identical to the undefined case.
  - HLT still freezes the sequencer regardless of `step`.
- `CTRL_SEQ_STEP_EN` undefined: the ports are absent and the sequencer free-runs.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants `OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`;
  - T-state one-hot localparams `T1`..`T6`;
  - control-word bit indices, used to build a 12-bit internal control word.
- Sub-module `tstate_ring`:
  - 6-bit one-hot ring with inputs `advance` and `hold`;
  - synchronous reset to T1.
- `ctrl_seq` contains the decode and `halted` logic.

## Test plan
- Reset then free run with `ir_opcode`=4'h0:
  - cycle 1: `pc_out`=`mar_in`=1, `t_state`=6'b000001;
  - cycle 2: `pc_inc`=1;
  - cycle 3: `ram_out`=`ir_in`=1;
  - cycle 4: `ir_out`=`mar_in`=1;
  - cycle 5: `ram_out`=`a_in`=1;
  - cycle 6: all 0;
  - cycle 7: T1 again.
- `ir_opcode`=4'h2 → T5: `ram_out`=`b_in`=`alu_sub`=1; T6: `alu_out`=`a_in`=`alu_sub`=1. Repeat with 4'h1 → `alu_sub`=0 throughout.
- `ir_opcode`=4'hE → T4: `a_out`=`out_in`=1; T5 and T6 quiet. Opcode 4'h7 → T4–T6 all strobes 0.
- `ir_opcode`=4'hF:
  - `halted`=1 from the cycle after T4;
  - `t_state`=6'b010000 held for 50 cycles with all strobes 0;
  - `rst` pulse → T1 with `halted`=0.
- `rst` asserted during T5 of ADD → strobes 0 that cycle; next cycle T1.
- With `CTRL_SEQ_STEP_EN`, `step_mode`=1, `step` pulsed every 4th cycle:
  - `pc_inc` is high for exactly one cycle per instruction;
  - `t_state` changes only after `step` cycles.
